rtc_apb_regs: RTL and testbench

APB3 slave register front-end that sits directly upstream of `rtc_top`, converting bus accesses into its update strobes, configuration levels and wide data words. Returns live RTC state with a coherent clock/date snapshot. Latches `event_o` into a maskable sticky interrupt. Single clock domain, shared with `rtc_top`.

---
 rtl/rtc_pkg.sv | 41 ++++
 rtl/rtc_apb_regs.sv | 229 ++++++++++++++++++++++
 tb/tb_rtc_apb_regs.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants for the RTC APB register front-end.
// Holds the register byte offsets, CTRL/STATUS bit positions, field widths
// and the APB transfer-phase state type.
package rtc_pkg;

    // Register byte offsets (decoded on PADDR[4:0], [1:0] must be zero).
    localparam logic [4:0] OFF_CTRL        = 5'h00;
    localparam logic [4:0] OFF_STATUS      = 5'h04;
    localparam logic [4:0] OFF_CLOCK       = 5'h08;
    localparam logic [4:0] OFF_DATE        = 5'h0C;
    localparam logic [4:0] OFF_TIMER       = 5'h10;
    localparam logic [4:0] OFF_ALARM_CLOCK = 5'h14;
    localparam logic [4:0] OFF_ALARM_DATE  = 5'h18;
    localparam logic [4:0] OFF_INIT_SEC    = 5'h1C;

    // CTRL bit positions.
    localparam int unsigned CTRL_TIMER_EN     = 0;
    localparam int unsigned CTRL_TIMER_RETRIG = 1;
    localparam int unsigned CTRL_ALARM_EN     = 2;
    localparam int unsigned CTRL_MASK_LSB     = 3;
    localparam int unsigned CTRL_IRQ_EN       = 9;
    localparam int unsigned CTRL_W            = 10;

    // STATUS bit positions.
    localparam int unsigned STATUS_PENDING = 0;
    localparam int unsigned STATUS_SNAP    = 1;

    // Field widths.
    localparam int unsigned CLOCK_W    = 22;
    localparam int unsigned DATE_W     = 32;
    localparam int unsigned TIMER_W    = 17;
    localparam int unsigned INIT_SEC_W = 10;
    localparam int unsigned MASK_W     = 6;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rtc_apb_regs.sv
// rtc_apb_regs: APB3 slave register front-end for rtc_top.
//   APB side : paddr_i/pwdata_i/pwrite_i/psel_i/penable_i in,
//              prdata_o/pready_o/pslverr_o out (zero wait states).
//   To RTC   : one-cycle *_update_o strobes, held write data words,
//              configuration levels (timer/alarm enables, alarm mask, init_sec).
//   From RTC : live clock/date/timer/alarm values and event_i.
//   irq_o    : registered event_pending & irq_en.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// APB_IDLE   | no transfer seen last cycle
// APB_SETUP  | last cycle was a setup phase; an enabled cycle now is ACCESS
// APB_ACCESS | last cycle was the access (commit) phase
module rtc_apb_regs
    import rtc_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      clock_update_o,
    output logic                      date_update_o,
    output logic                      timer_update_o,
    output logic                      alarm_update_clock_o,
    output logic                      alarm_update_date_o,
    output logic [CLOCK_W-1:0]        clock_wdata_o,
    output logic [DATE_W-1:0]         date_wdata_o,
    output logic [TIMER_W-1:0]        timer_target_o,
    output logic [CLOCK_W-1:0]        alarm_clock_wdata_o,
    output logic [DATE_W-1:0]         alarm_date_wdata_o,
    output logic [INIT_SEC_W-1:0]     init_sec_cnt_o,
    output logic                      timer_enable_o,
    output logic                      timer_retrig_o,
    output logic                      alarm_enable_o,
    output logic [MASK_W-1:0]         alarm_mask_o,
    input  logic [CLOCK_W-1:0]        clock_i,
    input  logic [DATE_W-1:0]         date_i,
    input  logic [TIMER_W-1:0]        timer_value_i,
    input  logic [CLOCK_W-1:0]        alarm_clock_i,
    input  logic [DATE_W-1:0]         alarm_date_i,
    input  logic                      event_i,
    output logic                      irq_o
);

    apb_state_e state_q, state_d;

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic                  pending_q, pending_d;
    logic                  snap_valid_q, snap_valid_d;
    logic [DATE_W-1:0]     date_shadow_q, date_shadow_d;
    logic [CLOCK_W-1:0]    clock_wdata_q, clock_wdata_d;
    logic [DATE_W-1:0]     date_wdata_q, date_wdata_d;
    logic [TIMER_W-1:0]    timer_target_q, timer_target_d;
    logic [CLOCK_W-1:0]    alarm_clock_q, alarm_clock_d;
    logic [DATE_W-1:0]     alarm_date_q, alarm_date_d;
    logic [INIT_SEC_W-1:0] init_sec_q, init_sec_d;
    logic [4:0]            upd_q, upd_d;   // {alarm_date, alarm_clock, timer, date, clock}
    logic                  event_dly_q, event_dly_d;
    logic                  irq_q, irq_d;

    logic        access;
    logic        addr_err;
    logic        wr_en;
    logic        rd_en;
    logic        status_clr;
    logic [4:0]  off;
    logic [31:0] rdata;

    assign off      = paddr_i[4:0];
    assign addr_err = (|paddr_i[APB_ADDR_WIDTH-1:5]) | (|paddr_i[1:0]);
    // An enabled cycle only commits when it follows a setup phase.
    assign access   = psel_i & penable_i & (state_q == APB_SETUP);
    assign wr_en    = access & pwrite_i & ~addr_err;
    assign rd_en    = access & ~pwrite_i & ~addr_err;

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:   if (psel_i & ~penable_i) state_d = APB_SETUP;
            APB_SETUP: begin
                if (psel_i & penable_i) state_d = APB_ACCESS;
                else if (!psel_i)       state_d = APB_IDLE;
            end
            APB_ACCESS: state_d = (psel_i & ~penable_i) ? APB_SETUP : APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:        rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            OFF_STATUS:      rdata = {30'b0, snap_valid_q, pending_q};
            OFF_CLOCK:       rdata = {{(32-CLOCK_W){1'b0}}, clock_i};
            OFF_DATE:        rdata = snap_valid_q ? date_shadow_q : date_i;
            OFF_TIMER:       rdata = {{(32-TIMER_W){1'b0}}, timer_value_i};
            OFF_ALARM_CLOCK: rdata = {{(32-CLOCK_W){1'b0}}, alarm_clock_i};
            OFF_ALARM_DATE:  rdata = alarm_date_i;
            OFF_INIT_SEC:    rdata = {{(32-INIT_SEC_W){1'b0}}, init_sec_q};
            default:         rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d         = ctrl_q;
        snap_valid_d   = snap_valid_q;
        date_shadow_d  = date_shadow_q;
        clock_wdata_d  = clock_wdata_q;
        date_wdata_d   = date_wdata_q;
        timer_target_d = timer_target_q;
        alarm_clock_d  = alarm_clock_q;
        alarm_date_d   = alarm_date_q;
        init_sec_d     = init_sec_q;
        upd_d          = '0;
        status_clr     = 1'b0;

        if (wr_en) begin
            case (off)
                OFF_CTRL:   ctrl_d     = pwdata_i[CTRL_W-1:0];
                OFF_STATUS: status_clr = pwdata_i[STATUS_PENDING];
                OFF_CLOCK: begin
                    clock_wdata_d = pwdata_i[CLOCK_W-1:0];
                    upd_d[0]      = 1'b1;
                    snap_valid_d  = 1'b0;
                end
                OFF_DATE: begin
                    date_wdata_d = pwdata_i;
                    upd_d[1]     = 1'b1;
                    snap_valid_d = 1'b0;
                end
                OFF_TIMER: begin
                    timer_target_d = pwdata_i[TIMER_W-1:0];
                    upd_d[2]       = 1'b1;
                end
                OFF_ALARM_CLOCK: begin
                    alarm_clock_d = pwdata_i[CLOCK_W-1:0];
                    upd_d[3]      = 1'b1;
                end
                OFF_ALARM_DATE: begin
                    alarm_date_d = pwdata_i;
                    upd_d[4]     = 1'b1;
                end
                OFF_INIT_SEC: init_sec_d = pwdata_i[INIT_SEC_W-1:0];
                default: ;
            endcase
        end

        // Clock read freezes the matching date so a following date read is coherent.
        if (rd_en) begin
            if (off == OFF_CLOCK) begin
                date_shadow_d = date_i;
                snap_valid_d  = 1'b1;
            end else if (off == OFF_DATE) begin
                snap_valid_d = 1'b0;
            end
        end
    end

    // A new edge overrides a simultaneous write-one-to-clear.
    assign event_dly_d = event_i;
    assign pending_d   = (event_i & ~event_dly_q) | (pending_q & ~status_clr);
    assign irq_d       = pending_q & ctrl_q[CTRL_IRQ_EN];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q        <= APB_IDLE;
            ctrl_q         <= '0;
            pending_q      <= 1'b0;
            snap_valid_q   <= 1'b0;
            date_shadow_q  <= '0;
            clock_wdata_q  <= '0;
            date_wdata_q   <= '0;
            timer_target_q <= '0;
            alarm_clock_q  <= '0;
            alarm_date_q   <= '0;
            init_sec_q     <= '0;
            upd_q          <= '0;
            event_dly_q    <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            ctrl_q         <= ctrl_d;
            pending_q      <= pending_d;
            snap_valid_q   <= snap_valid_d;
            date_shadow_q  <= date_shadow_d;
            clock_wdata_q  <= clock_wdata_d;
            date_wdata_q   <= date_wdata_d;
            timer_target_q <= timer_target_d;
            alarm_clock_q  <= alarm_clock_d;
            alarm_date_q   <= alarm_date_d;
            init_sec_q     <= init_sec_d;
            upd_q          <= upd_d;
            event_dly_q    <= event_dly_d;
            irq_q          <= irq_d;
        end
    end

    assign pready_o  = psel_i & penable_i;
    assign pslverr_o = access & addr_err;
    assign prdata_o  = rd_en ? rdata : 32'h0;

    assign clock_update_o       = upd_q[0];
    assign date_update_o        = upd_q[1];
    assign timer_update_o       = upd_q[2];
    assign alarm_update_clock_o = upd_q[3];
    assign alarm_update_date_o  = upd_q[4];

    assign clock_wdata_o       = clock_wdata_q;
    assign date_wdata_o        = date_wdata_q;
    assign timer_target_o      = timer_target_q;
    assign alarm_clock_wdata_o = alarm_clock_q;
    assign alarm_date_wdata_o  = alarm_date_q;
    assign init_sec_cnt_o      = init_sec_q;

    assign timer_enable_o = ctrl_q[CTRL_TIMER_EN];
    assign timer_retrig_o = ctrl_q[CTRL_TIMER_RETRIG];
    assign alarm_enable_o = ctrl_q[CTRL_ALARM_EN];
    assign alarm_mask_o   = ctrl_q[CTRL_MASK_LSB +: MASK_W];
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_rtc_apb_regs.sv
module tb_rtc_apb_regs;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [11:0] paddr_i;
    logic [31:0] pwdata_i;
    logic        pwrite_i, psel_i, penable_i;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic        clock_update_o, date_update_o, timer_update_o;
    logic        alarm_update_clock_o, alarm_update_date_o;
    logic [21:0] clock_wdata_o, alarm_clock_wdata_o;
    logic [31:0] date_wdata_o, alarm_date_wdata_o;
    logic [16:0] timer_target_o;
    logic [9:0]  init_sec_cnt_o;
    logic        timer_enable_o, timer_retrig_o, alarm_enable_o;
    logic [5:0]  alarm_mask_o;
    logic [21:0] clock_i, alarm_clock_i;
    logic [31:0] date_i, alarm_date_i;
    logic [16:0] timer_value_i;
    logic        event_i;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    rtc_apb_regs #(.APB_ADDR_WIDTH(12)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
        .psel_i(psel_i), .penable_i(penable_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .clock_update_o(clock_update_o), .date_update_o(date_update_o),
        .timer_update_o(timer_update_o), .alarm_update_clock_o(alarm_update_clock_o),
        .alarm_update_date_o(alarm_update_date_o),
        .clock_wdata_o(clock_wdata_o), .date_wdata_o(date_wdata_o),
        .timer_target_o(timer_target_o), .alarm_clock_wdata_o(alarm_clock_wdata_o),
        .alarm_date_wdata_o(alarm_date_wdata_o),
        .init_sec_cnt_o(init_sec_cnt_o), .timer_enable_o(timer_enable_o),
        .timer_retrig_o(timer_retrig_o), .alarm_enable_o(alarm_enable_o),
        .alarm_mask_o(alarm_mask_o),
        .clock_i(clock_i), .date_i(date_i), .timer_value_i(timer_value_i),
        .alarm_clock_i(alarm_clock_i), .alarm_date_i(alarm_date_i),
        .event_i(event_i), .irq_o(irq_o)
    );

    // Reference model: register contents by word index (offset/4).
    logic [31:0] m_reg [8];
    bit          m_strb [8];
    bit          m_pending, m_snap, m_irq, m_evt_prev, m_prev_setup;
    logic [31:0] m_shadow;

    initial begin
        for (int k = 0; k < 8; k++) begin
            m_reg[k]  = '0;
            m_strb[k] = 1'b0;
        end
        m_pending = 0; m_snap = 0; m_irq = 0; m_evt_prev = 0; m_prev_setup = 0;
        m_shadow = '0;
    end

    function automatic logic [31:0] fmask(int idx);
        case (idx)
            0, 7:    return 32'h0000_03FF;
            2, 5:    return 32'h003F_FFFF;
            3, 6:    return 32'hFFFF_FFFF;
            4:       return 32'h0001_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit addr_bad(logic [11:0] a);
        return ((a >> 5) != 0) || (a[1:0] != 2'b00);
    endfunction

    function automatic bit m_access();
        return psel_i && penable_i && m_prev_setup;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!m_access() || pwrite_i || addr_bad(paddr_i)) return 32'h0;
        case (int'(paddr_i[4:2]))
            0:       return m_reg[0];
            1:       return {30'b0, m_snap, m_pending};
            2:       return {10'b0, clock_i};
            3:       return m_snap ? m_shadow : date_i;
            4:       return {15'b0, timer_value_i};
            5:       return {10'b0, alarm_clock_i};
            6:       return alarm_date_i;
            default: return m_reg[7];
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin : model
        bit acc, bad, clr, ev_rise, nxt_irq;
        int idx;
        if (!rstn_i) begin
            for (int k = 0; k < 8; k++) begin
                m_reg[k]  = '0;
                m_strb[k] = 1'b0;
            end
            m_pending = 0; m_snap = 0; m_irq = 0; m_evt_prev = 0;
            m_shadow = '0;
        end else begin
            acc     = m_access();
            bad     = addr_bad(paddr_i);
            idx     = int'(paddr_i[4:2]);
            clr     = 0;
            nxt_irq = m_pending && m_reg[0][9];
            ev_rise = event_i && !m_evt_prev;
            for (int k = 0; k < 8; k++) m_strb[k] = 1'b0;
            if (acc && !bad) begin
                if (pwrite_i) begin
                    if (idx == 1) clr = pwdata_i[0];
                    else begin
                        m_reg[idx] = pwdata_i & fmask(idx);
                        if (idx >= 2 && idx <= 6) m_strb[idx] = 1'b1;
                    end
                    if (idx == 2 || idx == 3) m_snap = 0;
                end else begin
                    if (idx == 2) begin m_shadow = date_i; m_snap = 1; end
                    if (idx == 3) m_snap = 0;
                end
            end
            m_pending  = ev_rise || (m_pending && !clr);
            m_irq      = nxt_irq;
            m_evt_prev = event_i;
        end
        m_prev_setup = rstn_i && psel_i && !penable_i;
    end

    always @(negedge clk_i) begin : compare
        chk("prdata", prdata_o, exp_rdata());
        chk("pready", {31'b0, pready_o}, {31'b0, psel_i && penable_i});
        chk("pslverr", {31'b0, pslverr_o}, {31'b0, m_access() && addr_bad(paddr_i)});
        chk("clock_update", {31'b0, clock_update_o}, {31'b0, m_strb[2]});
        chk("date_update", {31'b0, date_update_o}, {31'b0, m_strb[3]});
        chk("timer_update", {31'b0, timer_update_o}, {31'b0, m_strb[4]});
        chk("alarm_update_clock", {31'b0, alarm_update_clock_o}, {31'b0, m_strb[5]});
        chk("alarm_update_date", {31'b0, alarm_update_date_o}, {31'b0, m_strb[6]});
        chk("clock_wdata", {10'b0, clock_wdata_o}, m_reg[2]);
        chk("date_wdata", date_wdata_o, m_reg[3]);
        chk("timer_target", {15'b0, timer_target_o}, m_reg[4]);
        chk("alarm_clock_wdata", {10'b0, alarm_clock_wdata_o}, m_reg[5]);
        chk("alarm_date_wdata", alarm_date_wdata_o, m_reg[6]);
        chk("init_sec", {22'b0, init_sec_cnt_o}, m_reg[7]);
        chk("ctrl_levels", {23'b0, alarm_mask_o, alarm_enable_o, timer_retrig_o, timer_enable_o},
            m_reg[0] & 32'h1FF);
        chk("irq", {31'b0, irq_o}, {31'b0, m_irq});
    end

    task automatic apb(input logic [11:0] a, input bit w, input logic [31:0] d,
                       input bit ev_at_access, output logic [31:0] rd, output logic err);
        @(posedge clk_i); #1;
        psel_i = 1; penable_i = 0; paddr_i = a; pwrite_i = w; pwdata_i = d;
        @(posedge clk_i); #1;
        penable_i = 1;
        if (ev_at_access) event_i = 1;
        @(negedge clk_i);
        rd = prdata_o; err = pslverr_o;
        @(posedge clk_i); #1;
        psel_i = 0; penable_i = 0; pwrite_i = 0;
    endtask

    logic [31:0] rd;
    logic        err;

    initial begin
        rstn_i = 0; paddr_i = '0; pwdata_i = '0; pwrite_i = 0; psel_i = 0; penable_i = 0;
        clock_i = '0; date_i = '0; timer_value_i = '0; alarm_clock_i = '0; alarm_date_i = '0;
        event_i = 0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1;
        @(negedge clk_i);
        chk("reset_irq", {31'b0, irq_o}, 32'h0);
        chk("reset_ctrl", {22'b0, alarm_mask_o, 1'b0, alarm_enable_o, timer_retrig_o, timer_enable_o}, 32'h0);

        // Clock write: data and single-cycle strobe right after commit.
        apb(12'h008, 1, 32'h0012_3456, 0, rd, err);
        chk("lit_clock_err", {31'b0, err}, 32'h0);
        @(negedge clk_i);
        chk("lit_clock_wdata", {10'b0, clock_wdata_o}, 32'h0012_3456);
        chk("lit_clock_strobe_hi", {31'b0, clock_update_o}, 32'h1);
        @(negedge clk_i);
        chk("lit_clock_strobe_lo", {31'b0, clock_update_o}, 32'h0);

        // Coherent snapshot.
        date_i = 32'h2024_0101;
        apb(12'h008, 0, 32'h0, 0, rd, err);
        date_i = 32'h2024_0102;
        apb(12'h00C, 0, 32'h0, 0, rd, err);
        chk("lit_snap_date", rd, 32'h2024_0101);
        apb(12'h004, 0, 32'h0, 0, rd, err);
        chk("lit_snap_cleared", rd & 32'h2, 32'h0);
        apb(12'h00C, 0, 32'h0, 0, rd, err);
        chk("lit_live_date", rd, 32'h2024_0102);

        // Event -> pending -> irq, RW1C clear, clear racing a new edge.
        apb(12'h000, 1, 32'h0000_0200, 0, rd, err);
        @(posedge clk_i); #1 event_i = 1;
        @(posedge clk_i); #1 event_i = 0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("lit_irq_set", {31'b0, irq_o}, 32'h1);
        apb(12'h004, 1, 32'h1, 0, rd, err);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("lit_irq_clr", {31'b0, irq_o}, 32'h0);
        apb(12'h004, 1, 32'h1, 1, rd, err);
        event_i = 0;
        apb(12'h004, 0, 32'h0, 0, rd, err);
        chk("lit_set_wins", rd & 32'h1, 32'h1);
        apb(12'h004, 1, 32'h1, 0, rd, err);

        // CTRL all functional bits.
        apb(12'h000, 1, 32'hFFFF_F1FF, 0, rd, err);
        @(negedge clk_i);
        chk("lit_ctrl_mask", {26'b0, alarm_mask_o}, 32'h3F);
        chk("lit_ctrl_en", {29'b0, alarm_enable_o, timer_retrig_o, timer_enable_o}, 32'h7);
        apb(12'h000, 0, 32'h0, 0, rd, err);
        chk("lit_ctrl_rd", rd, 32'h1FF);

        // Bad addresses.
        apb(12'h100, 1, 32'hFFFF_FFFF, 0, rd, err);
        chk("lit_err_hi", {31'b0, err}, 32'h1);
        apb(12'h002, 1, 32'hFFFF_FFFF, 0, rd, err);
        chk("lit_err_unal", {31'b0, err}, 32'h1);
        apb(12'h108, 0, 32'h0, 0, rd, err);
        chk("lit_err_rdata", rd, 32'h0);
        apb(12'h000, 0, 32'h0, 0, rd, err);
        chk("lit_err_ctrl_kept", rd, 32'h1FF);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [11:0] a;
            clock_i       = 22'($urandom);
            date_i        = $urandom;
            timer_value_i = 17'($urandom);
            alarm_clock_i = 22'($urandom);
            alarm_date_i  = $urandom;
            event_i       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) a = 12'($urandom_range(0, 7) << 2);
            else                           a = 12'($urandom);
            apb(a, 1'($urandom_range(0, 1)), $urandom, 0, rd, err);
        end
        event_i = 0;

        // Reset during the access phase of a timer write.
        apb(12'h010, 1, 32'h0000_0005, 0, rd, err);
        @(posedge clk_i); #1;
        psel_i = 1; penable_i = 0; paddr_i = 12'h010; pwrite_i = 1; pwdata_i = 32'h0001_ABCD;
        @(posedge clk_i); #1;
        penable_i = 1; rstn_i = 0;
        @(posedge clk_i); #1;
        rstn_i = 1; psel_i = 0; penable_i = 0; pwrite_i = 0;
        @(negedge clk_i);
        chk("lit_rst_strobe", {31'b0, timer_update_o}, 32'h0);
        chk("lit_rst_target", {15'b0, timer_target_o}, 32'h0);
        chk("lit_rst_clock", {10'b0, clock_wdata_o}, 32'h0);
        chk("lit_rst_irq", {31'b0, irq_o}, 32'h0);
        apb(12'h000, 0, 32'h0, 0, rd, err);
        chk("lit_rst_ctrl", rd, 32'h0);
        repeat (2) @(posedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
